// File: rtl/trace_dumper.sv
// Wishbone master that reads a trace logger's trig and data regions word by word
// and streams them out as a framed, MSB-first byte sequence.
module trace_dumper #(
  parameter int DATA_WORDS = 3,
  parameter int IDX_W      = 10,
  parameter int WB_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        abort_o,
  output logic [23:2] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam logic [7:0]  HDR_SYNC  = 8'hA5;
  localparam logic [7:0]  HDR_COUNT = 8'(DATA_WORDS + 1);
  localparam logic [7:0]  TRL_OK    = 8'h5A;
  localparam logic [7:0]  TRL_ABORT = 8'hEE;
  localparam logic [7:0]  TMO_LAST  = 8'(WB_TIMEOUT - 1);
  localparam logic [11:0] LAST_REG  = 12'(DATA_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    REQ,
    SHIFT,
    TRL
  } state_t;

  state_t            state_reg, state_next;
  logic [11:0]       region_reg, region_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [31:0]       shift_reg, shift_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [7:0]        timeout_reg, timeout_next;
  logic              abort_reg, abort_next;
  logic              done_reg, done_next;

  logic [31:0]       shift_shl;
  logic              idx_last;
  logic [9:0]        idx_ext;

  // Byte lanes move up one position per transfer; the bottom lane refills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi == 0) begin : g_bottom
        assign shift_shl[7:0] = 8'h00;
      end else begin : g_upper
        assign shift_shl[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  assign idx_last = (index_reg == {IDX_W{1'b1}});
  assign idx_ext  = 10'(index_reg);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg    <= IDLE;
      region_reg   <= '0;
      index_reg    <= '0;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      timeout_reg  <= '0;
      abort_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      region_reg   <= region_next;
      index_reg    <= index_next;
      shift_reg    <= shift_next;
      byte_cnt_reg <= byte_cnt_next;
      timeout_reg  <= timeout_next;
      abort_reg    <= abort_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    region_next   = region_reg;
    index_next    = index_reg;
    shift_next    = shift_reg;
    byte_cnt_next = byte_cnt_reg;
    timeout_next  = timeout_reg;
    abort_next    = abort_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          abort_next  = 1'b0;
          region_next = '0;
          index_next  = '0;
          state_next  = HDR0;
        end
      end
      HDR0: begin
        if (tx_ready_i) state_next = HDR1;
      end
      HDR1: begin
        if (tx_ready_i) begin
          timeout_next = '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        // err takes priority over a simultaneous ack
        if (wbm_err_i) begin
          abort_next = 1'b1;
          state_next = TRL;
        end else if (wbm_ack_i) begin
          shift_next    = wbm_dat_i;
          byte_cnt_next = '0;
          state_next    = SHIFT;
        end else if (timeout_reg == TMO_LAST) begin
          abort_next = 1'b1;
          state_next = TRL;
        end else begin
          timeout_next = timeout_reg + 8'd1;
        end
      end
      SHIFT: begin
        if (tx_ready_i) begin
          shift_next    = shift_shl;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            if (idx_last && region_reg == LAST_REG) begin
              state_next = TRL;
            end else begin
              // index wraps naturally; a wrap moves on to the next region
              index_next   = index_reg + 1'b1;
              if (idx_last) region_next = region_reg + 12'd1;
              timeout_next = '0;
              state_next   = REQ;
            end
          end
        end
      end
      TRL: begin
        if (tx_ready_i) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_data_o  = 8'h00;
    tx_valid_o = 1'b0;
    case (state_reg)
      HDR0: begin
        tx_data_o  = HDR_SYNC;
        tx_valid_o = 1'b1;
      end
      HDR1: begin
        tx_data_o  = HDR_COUNT;
        tx_valid_o = 1'b1;
      end
      SHIFT: begin
        tx_data_o  = shift_reg[31:24];
        tx_valid_o = 1'b1;
      end
      TRL: begin
        tx_data_o  = abort_reg ? TRL_ABORT : TRL_OK;
        tx_valid_o = 1'b1;
      end
      default: begin
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
      end
    endcase
  end

  assign busy_o    = (state_reg != IDLE);
  assign done_o    = done_reg;
  assign abort_o   = abort_reg;
  assign wbm_cyc_o = (state_reg == REQ);
  assign wbm_stb_o = (state_reg == REQ);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = {region_reg, idx_ext};

endmodule

// File: tb/tb_trace_dumper.sv
// Directed bench for trace_dumper: full frame, stalls, bus error, timeout,
// start while busy and reset mid-dump, with a reactive Wishbone slave.
module tb_trace_dumper;

  logic        clk = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, abort;
  logic [23:2] adr;
  logic [31:0] dat = 32'h0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  trace_dumper #(.DATA_WORDS(1), .IDX_W(2), .WB_TIMEOUT(255)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (wb_rst_ni),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .abort_o    (abort),
    .wbm_adr_o  (adr),
    .wbm_dat_i  (dat),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus knobs (written only by the initial block)
  bit ready_toggle = 1'b0;
  bit ready_level  = 1'b1;
  bit no_ack       = 1'b0;
  bit fixed_word   = 1'b0;
  int err_at       = 0;

  function automatic logic [31:0] slave_word(input logic [23:0] ba);
    return {ba[7:0] ^ 8'h11, ba[15:8] ^ 8'h22, 8'h33, ba[7:0]};
  endfunction

  // slave: one-cycle ack/err after seeing stb, never twice in a row
  int rd_cnt = 0;
  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (cyc && stb && !ack && !err && !no_ack) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_cnt + 1 == err_at) err <= 1'b1;
      else begin
        ack <= 1'b1;
        dat <= fixed_word ? 32'h12345678 : slave_word({adr, 2'b00});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ready = ready_toggle ? ~tx_ready : ready_level;
  end

  // monitor (owns everything it writes)
  logic [7:0]  rx_q[$];
  logic [23:0] addr_q[$];
  int done_cnt = 0, stall_bad = 0, stall_seen = 0, err_drop_bad = 0, cyc_cnt = 0;
  bit prev_stall = 0, prev_err = 0;
  logic [7:0] prev_data = 8'h0;
  always @(negedge clk) begin
    if (!wb_rst_ni) begin
      prev_stall = 0;
      prev_err   = 0;
    end else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stall_bad++;
      if (prev_err && (cyc || stb)) err_drop_bad++;
      if (tx_valid && !tx_ready) stall_seen++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_err   = err && cyc && stb;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (cyc && stb && ack) addr_q.push_back({adr, 2'b00});
      if (done) done_cnt++;
      if (cyc) cyc_cnt++;
    end
  end

  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input int nwords, input bit fixed, input bit aborted);
    logic [23:0] ba;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    for (int i = 0; i < nwords; i++) begin
      ba = 24'((i / 4) * 32'h1000 + (i % 4) * 4);
      w  = fixed ? 32'h12345678 : slave_word(ba);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
    exp_q.push_back(aborted ? 8'hEE : 8'h5A);
  endtask

  task automatic check_frame(input string tag, input int base);
    int got;
    got = rx_q.size() - base;
    check({tag, "_len"}, 32'(got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[base + i]}, {24'h0, exp_q[i]});
  endtask

  task automatic check_addrs(input string tag, input int base, input int n);
    logic [23:0] ba;
    check({tag, "_nreads"}, 32'(addr_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < addr_q.size(); i++) begin
      ba = 24'((i / 4) * 32'h1000 + (i % 4) * 4);
      check($sformatf("%s_addr%0d", tag, i), {8'h0, addr_q[base + i]}, {8'h0, ba});
    end
  endtask

  int rx_base, ad_base, dn_base, snap;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_cyc", {30'h0, cyc, stb}, 32'h0);
    check("rst_adr", {10'h0, adr}, 32'h0);
    check("rst_abort_done", {30'h0, abort, done}, 32'h0);
    check("rst_we_sel", {27'h0, we, sel}, 32'h0000000F);
    @(posedge clk); #1 wb_rst_ni = 1'b1;

    // full dump, with a second start while busy
    rx_base = rx_q.size(); ad_base = addr_q.size(); dn_base = done_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 check("busy_mid", {31'h0, busy}, 32'h1);
    pulse_start();
    wait_done(dn_base + 1, 2000);
    repeat (40) @(posedge clk);
    #1;
    build_frame(8, 1'b0, 1'b0);
    check_frame("full", rx_base);
    check_addrs("full", ad_base, 8);
    check("full_done_once", 32'(done_cnt - dn_base), 32'h1);
    check("full_idle", {30'h0, busy, abort}, 32'h0);

    // stalled sink with a fixed slave word
    fixed_word = 1'b1; ready_toggle = 1'b1;
    rx_base = rx_q.size(); dn_base = done_cnt; snap = stall_bad;
    pulse_start();
    wait_done(dn_base + 1, 3000);
    ready_toggle = 1'b0; fixed_word = 1'b0;
    build_frame(8, 1'b1, 1'b0);
    check_frame("stall", rx_base);
    check("stall_stable", 32'(stall_bad - snap), 32'h0);
    check("stall_seen", {31'h0, stall_seen > 0}, 32'h1);

    // bus error on the third read
    err_at = rd_cnt + 3;
    rx_base = rx_q.size(); ad_base = addr_q.size(); dn_base = done_cnt; snap = err_drop_bad;
    pulse_start();
    wait_done(dn_base + 1, 2000);
    err_at = 0;
    build_frame(2, 1'b0, 1'b1);
    check_frame("err", rx_base);
    check_addrs("err", ad_base, 2);
    check("err_abort", {31'h0, abort}, 32'h1);
    check("err_cyc_drop", 32'(err_drop_bad - snap), 32'h0);
    check("err_done_once", 32'(done_cnt - dn_base), 32'h1);
    rx_base = rx_q.size(); dn_base = done_cnt;
    pulse_start();
    check("restart_abort_clr", {31'h0, abort}, 32'h0);
    wait_done(dn_base + 1, 2000);
    build_frame(8, 1'b0, 1'b0);
    check_frame("after_err", rx_base);

    // slave never answers
    no_ack = 1'b1;
    rx_base = rx_q.size(); ad_base = addr_q.size(); dn_base = done_cnt; snap = cyc_cnt;
    pulse_start();
    wait_done(dn_base + 1, 1000);
    repeat (20) @(posedge clk);
    #1;
    no_ack = 1'b0;
    build_frame(0, 1'b0, 1'b1);
    check_frame("tmo", rx_base);
    check("tmo_req_cycles", 32'(cyc_cnt - snap), 32'd255);
    check("tmo_abort", {31'h0, abort}, 32'h1);
    check("tmo_nreads", 32'(addr_q.size() - ad_base), 32'h0);

    // reset while stalled in SHIFT
    rx_base = rx_q.size();
    pulse_start();
    snap = 0;
    while (rx_q.size() - rx_base < 3 && snap < 200) begin
      @(posedge clk);
      snap++;
    end
    ready_level = 1'b0;
    @(negedge clk);
    check("pre_rst_busy_valid", {30'h0, busy, tx_valid}, 32'h3);
    #1 wb_rst_ni = 1'b0;
    #1;
    check("mid_rst_busy_valid", {30'h0, busy, tx_valid}, 32'h0);
    check("mid_rst_cyc_stb", {30'h0, cyc, stb}, 32'h0);
    @(posedge clk); #1 wb_rst_ni = 1'b1; ready_level = 1'b1;
    rx_base = rx_q.size(); dn_base = done_cnt;
    pulse_start();
    wait_done(dn_base + 1, 2000);
    build_frame(8, 1'b0, 1'b0);
    check_frame("post_rst", rx_base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
